// File: rtl/mult_sched_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
// tag_t follows each issued operand pair through the multiplier latency so
// the product can be routed back to the requester that issued it.
package mult_sched_pkg;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 12;
   localparam int MLAT_DEF  = 3;

   // Requester tag carried alongside an operand pair; id covers up to 8 requesters.
   typedef struct packed {
      logic       v;
      logic [2:0] id;
   } tag_t;

   // One-hot decode of a requester id; bits at or above nreq stay clear.
   function automatic logic [7:0] onehot(input logic [2:0] id, input int nreq);
      logic [7:0] oh;
      oh = '0;
      for (int i = 0; i < 8; i++) begin
         if ((i < nreq) && (id == 3'(i))) begin
            oh[i] = 1'b1;
         end
      end
      return oh;
   endfunction

endpackage : mult_sched_pkg

// File: rtl/mult_rr_sched_if.sv
// Request / multiplier / response bundle of the round-robin multiplier scheduler.
// slave  : the scheduler itself.
// master : the requesters together with the external multiplier.
interface mult_rr_sched_if #(
   parameter int NREQ  = mult_sched_pkg::NREQ_DEF,
   parameter int WIDTH = mult_sched_pkg::WIDTH_DEF,
   parameter int OWID  = 2 * WIDTH
);

   logic                    stall;
   logic [NREQ-1:0]         req_valid;
   logic [NREQ*WIDTH-1:0]   req_a;
   logic [NREQ*WIDTH-1:0]   req_b;
   logic [NREQ-1:0]         req_ready;
   logic [WIDTH-1:0]        mul_a;
   logic [WIDTH-1:0]        mul_b;
   logic [OWID:0]           mul_o;
   logic [NREQ-1:0]         rsp_valid;
   logic [OWID:0]           rsp_data;

   modport slave (
      input  stall, req_valid, req_a, req_b, mul_o,
      output req_ready, mul_a, mul_b, rsp_valid, rsp_data
   );

   modport master (
      output stall, req_valid, req_a, req_b, mul_o,
      input  req_ready, mul_a, mul_b, rsp_valid, rsp_data
   );

endinterface : mult_rr_sched_if

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches i_ptr+1, i_ptr+2, ... modulo NREQ and grants the first active
// request; o_gnt is one-hot (or zero), o_gnt_id is its index.
module rr_arbiter
   import mult_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [2:0]      i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [2:0]      o_gnt_id
);

   logic w_found;

   // Two passes: indices above the pointer first, then wrap to indices at or below it.
   always_comb begin
      // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
      o_gnt    = '0;
      o_gnt_id = '0;
      w_found  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && i_req[i] && (i > int'(i_ptr))) begin
            w_found  = 1'b1;
            o_gnt[i] = 1'b1;
            o_gnt_id = 3'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && i_req[i] && (i <= int'(i_ptr))) begin
            w_found  = 1'b1;
            o_gnt[i] = 1'b1;
            o_gnt_id = 3'(i);
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ requesters.
// At most one operand pair is issued per cycle; a tag follows it through the
// multiplier latency and routes the product back as a one-hot response.
// A grant in cycle t produces rsp_valid during cycle t+MLAT+2.
// Optional feature macro: MULT_RR_SCHED_PERF_EN adds saturating busy_cnt and
// stall_cnt outputs; without it those ports and counters do not exist.
module mult_rr_sched
   import mult_sched_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int OWID  = 2 * WIDTH,
   parameter int MLAT  = MLAT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   mult_rr_sched_if.slave     sched_bus
`ifdef MULT_RR_SCHED_PERF_EN
   ,
   output logic [31:0]        busy_cnt,
   output logic [31:0]        stall_cnt
`endif
);

   logic [2:0]       r_ptr;
   logic [NREQ-1:0]  w_gnt;
   logic [2:0]       w_gnt_id;
   logic [NREQ-1:0]  w_ready;
   logic             w_xfer;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic [WIDTH-1:0] r_mul_a;
   logic [WIDTH-1:0] r_mul_b;
   tag_t             r_issue_tag;
   tag_t             r_tag_pipe [MLAT];
   tag_t             w_out_tag;
   logic [NREQ-1:0]  r_rsp_valid;
   logic [OWID:0]    r_rsp_data;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .i_req    (sched_bus.req_valid),
      .i_ptr    (r_ptr),
      .o_gnt    (w_gnt),
      .o_gnt_id (w_gnt_id)
   );

   // Stall masks grants only; the arbiter only grants active requesters,
   // so any ready bit set means a transfer this cycle.
   assign w_ready             = sched_bus.stall ? '0 : w_gnt;
   assign w_xfer              = |w_ready;
   assign sched_bus.req_ready = w_ready;

   // Select the granted requester's operand pair.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_ready[i]) begin
            w_sel_a = sched_bus.req_a[i*WIDTH +: WIDTH];
            w_sel_b = sched_bus.req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Operand registers feeding the multiplier; hold their value on idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mul_a <= '0;
         r_mul_b <= '0;
      end else if (w_xfer) begin
         // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
         r_mul_a <= w_sel_a;
         r_mul_b <= w_sel_b;
      end
   end

   assign sched_bus.mul_a = r_mul_a;
   assign sched_bus.mul_b = r_mul_b;

   // Round-robin pointer remembers the last granted requester.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= 3'(NREQ - 1);
      end else if (w_xfer) begin
         r_ptr <= w_gnt_id;
      end
   end

   // Tag path: r_issue_tag sits beside mul_a/mul_b, then MLAT stages track the multiplier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the tag pipe is reset because its valid bits are control state; a stale v=1 would fire a bogus response.
         r_issue_tag <= '0;
         for (int i = 0; i < MLAT; i++) begin
            r_tag_pipe[i] <= '0;
         end
      end else begin
         r_issue_tag.v  <= w_xfer;
         r_issue_tag.id <= w_gnt_id;
         r_tag_pipe[0]  <= r_issue_tag;
         for (int i = 1; i < MLAT; i++) begin
            r_tag_pipe[i] <= r_tag_pipe[i-1];
         end
      end
   end

   assign w_out_tag = r_tag_pipe[MLAT-1];

   // Response register: capture the product when its tag emerges; data holds otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
      end else if (w_out_tag.v) begin
         r_rsp_valid <= NREQ'(onehot(w_out_tag.id, NREQ));
         r_rsp_data  <= sched_bus.mul_o;
      end else begin
         r_rsp_valid <= '0;
      end
   end

   assign sched_bus.rsp_valid = r_rsp_valid;
   assign sched_bus.rsp_data  = r_rsp_data;

`ifdef MULT_RR_SCHED_PERF_EN
   logic [31:0] r_busy_cnt;
   logic [31:0] r_stall_cnt;
   logic        w_stall_pend;

   // A stalled cycle only counts when someone was actually waiting.
   assign w_stall_pend = sched_bus.stall & (|sched_bus.req_valid);

   // Saturating utilisation counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_xfer && (r_busy_cnt != 32'hFFFF_FFFF)) begin
            r_busy_cnt <= r_busy_cnt + 32'd1;
         end
         if (w_stall_pend && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign busy_cnt  = r_busy_cnt;
   assign stall_cnt = r_stall_cnt;
`else
   // Performance counters are not built: no ports, no counter logic.
`endif

endmodule : mult_rr_sched

// File: tb/tb_mult_rr_sched.sv
// Self-checking bench for mult_rr_sched.
// A behavioural MLAT-cycle multiplier drives mul_o; a reference model predicts
// grants (rotating search from the last grant), and a queue of expected
// responses (requester, product, due cycle = grant cycle + MLAT + 2).
// Define MULT_RR_SCHED_PERF_EN to also check busy_cnt / stall_cnt.
module tb_mult_rr_sched;
   import mult_sched_pkg::*;

   localparam int NREQ    = NREQ_DEF;
   localparam int WIDTH   = WIDTH_DEF;
   localparam int OWID    = 2 * WIDTH;
   localparam int MLAT    = MLAT_DEF;
   localparam int RSP_LAT = MLAT + 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   mult_rr_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .OWID(OWID)) bus ();

`ifdef MULT_RR_SCHED_PERF_EN
   logic [31:0] busy_cnt;
   logic [31:0] stall_cnt;
`endif

   mult_rr_sched #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .OWID  (OWID),
      .MLAT  (MLAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sched_bus (bus)
`ifdef MULT_RR_SCHED_PERF_EN
      ,
      .busy_cnt  (busy_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   // Behavioural multiplier: product of mul_a/mul_b appears on mul_o MLAT cycles later.
   logic [OWID:0] mpipe [MLAT];
   always @(posedge clk) begin
      mpipe[0] <= (OWID+1)'(bus.mul_a) * (OWID+1)'(bus.mul_b);
      for (int i = 1; i < MLAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign bus.mul_o = mpipe[MLAT-1];

   typedef struct {
      int due;
      int id;
      int prod;
   } exp_t;

   exp_t          exp_q[$];
   int            m_ptr;
   logic [OWID:0] m_data;
   int            m_busy;
   int            m_stall;
   int            cyc;
   int            n_checks;
   int            n_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic set_op(input int i, input int a, input int b);
      bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
      bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NREQ; i++) set_op(i, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
   endtask

   // One clock cycle: check outputs mid-cycle against the model, then advance the model.
   task automatic tick();
      int               g;
      int               a;
      int               b;
      exp_t             e;
      logic [NREQ-1:0]  exp_ready;
      logic [NREQ-1:0]  exp_rv;
      @(negedge clk);
      g = -1;
      if (!bus.stall) begin
         for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && bus.req_valid[idx]) g = idx;
         end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));

      exp_rv = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         exp_rv[e.id] = 1'b1;
         m_data = (OWID+1)'(e.prod);
      end
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      check("rsp_data", 32'(bus.rsp_data), 32'(m_data));
`ifdef MULT_RR_SCHED_PERF_EN
      check("busy_cnt", busy_cnt, 32'(m_busy));
      check("stall_cnt", stall_cnt, 32'(m_stall));
`endif

      if (g >= 0) begin
         a = int'(bus.req_a[g*WIDTH +: WIDTH]);
         b = int'(bus.req_b[g*WIDTH +: WIDTH]);
         e.due  = cyc + RSP_LAT;
         e.id   = g;
         e.prod = a * b;
         exp_q.push_back(e);
         m_ptr = g;
         m_busy++;
      end
      if (bus.stall && (|bus.req_valid)) m_stall++;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      bus.req_valid = '0;
      bus.stall     = 1'b0;
      repeat (n) tick();
   endtask

   // Asynchronous reset pulse: outputs must clear immediately, in-flight work is dropped.
   task automatic pulse_rst();
      bus.req_valid = '0;
      bus.stall     = 1'b0;
      rst = 1'b1;
      #2;
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      check("rst_mul_a", 32'(bus.mul_a), 32'd0);
      check("rst_mul_b", 32'(bus.mul_b), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
`ifdef MULT_RR_SCHED_PERF_EN
      check("rst_busy_cnt", busy_cnt, 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
      exp_q.delete();
      m_ptr   = NREQ - 1;
      m_data  = '0;
      m_busy  = 0;
      m_stall = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      bus.stall     = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      #1;
      pulse_rst();

      // Single transfer: 3328 * 17 returns to requester 0 five cycles later.
      set_op(0, 3328, 17);
      bus.req_valid = 4'b0001;
      tick();
      idle(RSP_LAT + 1);

      // All requesters valid: grants 0,1,2,3,0,1,2,3 and products 2,4,6,8 repeating.
      for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 2);
      bus.req_valid = 4'b1111;
      repeat (8) tick();
      idle(RSP_LAT + 1);

      // Requesters 1 and 3 alternate; stall in cycles 2-3 of the run.
      rand_ops();
      bus.req_valid = 4'b1010;
      for (int c = 0; c < 8; c++) begin
         bus.stall = (c == 2 || c == 3);
         tick();
      end
      idle(RSP_LAT + 1);

      // Three grants then reset: their products must never be reported.
      rand_ops();
      bus.req_valid = 4'b1111;
      repeat (3) tick();
      pulse_rst();
      rand_ops();
      bus.req_valid = 4'b1000;
      tick();
      idle(RSP_LAT + 1);

      // Only requester 2 valid: granted every cycle, six back-to-back responses.
      bus.req_valid = 4'b0100;
      repeat (6) begin
         rand_ops();
         tick();
      end
      idle(RSP_LAT + 1);

      // Randomised traffic with occasional stalls.
      repeat (400) begin
         rand_ops();
         bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         bus.stall     = ($urandom_range(0, 7) == 0);
         tick();
      end
      idle(RSP_LAT + 1);

      // Ten transfers then three stalled cycles with a pending request.
      pulse_rst();
      bus.req_valid = 4'b0001;
      repeat (10) begin
         rand_ops();
         tick();
      end
      bus.stall = 1'b1;
      repeat (3) tick();
      idle(1);
`ifdef MULT_RR_SCHED_PERF_EN
      check("busy_cnt_10", busy_cnt, 32'd10);
      check("stall_cnt_3", stall_cnt, 32'd3);
`endif
      idle(RSP_LAT + 1);

      check("drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mult_rr_sched
